ace_ccu_snoop_scheduler: RTL and testbench
==========================================

Name: ace_ccu_snoop_scheduler

Overview:
- Arbitrates cache-line snoop requests from the CCU master-path groups onto the single snoop-interconnect input.
- Issues a snoop only when no other snoop to the same conflict-index line is in flight.
- Tracks in-flight snoops in a small slot table; each slot is freed when the interconnect reports completion.
- Sits between the per-group snoop request sources and ace_ccu_snoop_interconnect. The conflict manager's stall signal also feeds it.

Parameters:
NoReq, 4, number of requesters (at least 2)
CmAddrWidth, 8, width of the conflict-index (line address slice)
MaxOutstanding, 4, number of in-flight slot entries (at least 1)
SlotWidth, $clog2(MaxOutstanding) with a minimum of 1, derived width of a slot id
IdxWidth, $clog2(NoReq), derived width of a requester index

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  NoReq  per-requester snoop request valid
req_addr_i  in  NoReq x CmAddrWidth  per-requester conflict index
req_ready_o  out  NoReq  per-requester accept; a request transfers on valid and ready
stall_i  in  1  conflict-manager stall; blocks new issue while high
snp_valid_o  out  1  issued snoop valid
snp_req_idx_o  out  IdxWidth  requester index of the issued snoop
snp_addr_o  out  CmAddrWidth  conflict index of the issued snoop
snp_slot_o  out  SlotWidth  slot allocated to the issued snoop
snp_ready_i  in  1  interconnect accept
done_valid_i  in  1  snoop completion strobe
done_slot_i  in  SlotWidth  slot being completed
busy_cnt_o  out  SlotWidth+1  number of occupied slots

Behaviour:
- Reset (async, rst_i=1):
  - all slots free; output register EMPTY; round-robin pointer = 0.
  - snp_valid_o=0; snp_req_idx_o, snp_addr_o and snp_slot_o = 0.
  - req_ready_o = all 0; busy_cnt_o = 0.
  - Reset asserted mid-operation discards every slot and any held snoop. Completions for discarded slots are not expected after reset.
- Eligibility of requester i in a cycle requires all of the following:
  - req_valid_i[i] is high;
  - req_addr_i[i] matches no occupied slot's address. Matching uses the current table, so a slot being freed this cycle still blocks (one-cycle conservative).
- Load condition: stall_i=0, at least one free slot, at least one eligible requester, and the output register is EMPTY or (FULL and snp_ready_i=1).
- On a load:
  - Winner = first eligible requester at or after the pointer, wrapping modulo NoReq.
  - req_ready_o[winner]=1 combinationally in that cycle; every other bit of req_ready_o is 0.
  - Next edge: the output register loads winner, address and slot; the slot is marked occupied with that address; pointer = (winner+1) mod NoReq.
  - The allocated slot is the lowest-index free slot, taken from the pre-edge free vector. A slot freed by done in the same cycle becomes allocatable in the next cycle.
- Latency: a request accepted in cycle N appears on snp_valid_o in cycle N+1.
- Output register FSM, states EMPTY and FULL:
  - EMPTY to FULL on a load.
  - FULL to EMPTY on snp_ready_i=1 with no load.
  - FULL stays FULL on snp_ready_i=1 with a load (back-to-back issue).
  - FULL stays FULL with all outputs stable while snp_ready_i=0; stall_i does not drop a held snoop.
- Completion:
  - done_valid_i=1 frees done_slot_i at the edge.
  - A completion for an already-free slot is ignored and flagged by an assertion.
  - A completion for the slot currently held in FULL is legal and frees it (early completion is allowed).
- Simultaneous requesters:
  - Two eligible requesters with the same address in the same cycle: only the winner is accepted; the loser is blocked by the table from the next cycle onward.
  - Only one load occurs per cycle.
- Full table: no load occurs; valid requesters see ready=0 and must hold their request.
- Counter: busy_cnt_o = occupied slots. It increments on a load, decrements on a valid completion, and is unchanged when both occur in the same cycle. It never exceeds MaxOutstanding.
- Assertions:
  - req_valid_i and req_addr_i stay stable until accepted.
  - done_slot_i < MaxOutstanding.

Test Plan:
- Reset then a single request: req 0 with addr 0x12 in cycle 1 gives req_ready_o=0001 in cycle 1, then snp_valid_o=1 with idx 0, addr 0x12, slot 0 in cycle 2; busy_cnt_o=1.
- Round-robin: all four requesters valid with distinct addresses 0x01..0x04 and snp_ready_i=1 constantly gives grants in idx order 0,1,2,3 and slots 0,1,2,3; a fifth request then waits with busy_cnt_o=4.
- Conflict: slot 0 holds 0x20 and req 1 requests 0x20, so req_ready_o[1] stays 0. done_slot_i=0 in cycle N gives req_ready_o[1]=1 in cycle N+1 and an issue in cycle N+2 on slot 0.
- Backpressure: snp_ready_i=0 for 5 cycles keeps the idx, addr and slot outputs stable and gives no further accepts. Raising snp_ready_i with a request pending gives a back-to-back load in the same cycle.
- stall_i=1 for 3 cycles with requests pending: no accepts and busy_cnt_o unchanged; the first accept comes in the cycle stall_i falls.
- Mid-operation reset with 3 slots busy and FULL: rst_i pulse gives busy_cnt_o=0, snp_valid_o=0 and pointer 0; the next grant goes to requester 0.

Source files
------------

// File: rtl/ace_ccu_snoop_scheduler.sv
// Snoop issue scheduler: round-robin arbitration of per-group snoop requests onto the
// single interconnect input, blocking any request whose line is already in flight.
module ace_ccu_snoop_scheduler #(
    parameter int unsigned NoReq          = 4,
    parameter int unsigned CmAddrWidth    = 8,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned SlotWidth      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
    parameter int unsigned IdxWidth       = $clog2(NoReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NoReq-1:0]             req_valid_i,
    input  logic [NoReq*CmAddrWidth-1:0] req_addr_i,
    output logic [NoReq-1:0]             req_ready_o,
    input  logic                         stall_i,
    output logic                         snp_valid_o,
    output logic [IdxWidth-1:0]          snp_req_idx_o,
    output logic [CmAddrWidth-1:0]       snp_addr_o,
    output logic [SlotWidth-1:0]         snp_slot_o,
    input  logic                         snp_ready_i,
    input  logic                         done_valid_i,
    input  logic [SlotWidth-1:0]         done_slot_i,
    output logic [SlotWidth:0]           busy_cnt_o
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                   state_q, state_d;
    logic [MaxOutstanding-1:0] slot_busy_q;
    logic [CmAddrWidth-1:0]   slot_addr_q [MaxOutstanding];
    logic [IdxWidth-1:0]      ptr_q;
    logic [IdxWidth-1:0]      req_idx_q;
    logic [CmAddrWidth-1:0]   addr_q;
    logic [SlotWidth-1:0]     slot_q;
    logic [SlotWidth:0]       busy_q;

    logic [NoReq-1:0]         eligible;
    logic [IdxWidth-1:0]      winner;
    logic [IdxWidth-1:0]      cand;
    logic                     found_winner;
    logic [SlotWidth-1:0]     free_slot;
    logic                     found_free;
    logic [CmAddrWidth-1:0]   sel_addr;
    logic                     load;
    logic                     done_hit;

    // A slot being freed this cycle still blocks its line until the edge.
    for (genvar i = 0; i < NoReq; i++) begin : g_elig
        logic [MaxOutstanding-1:0] hit;
        for (genvar s = 0; s < MaxOutstanding; s++) begin : g_slot
            assign hit[s] = slot_busy_q[s] &&
                            (slot_addr_q[s] == req_addr_i[i*CmAddrWidth +: CmAddrWidth]);
        end
        assign eligible[i] = req_valid_i[i] && !(|hit);
    end

    always_comb begin
        winner       = '0;
        cand         = '0;
        found_winner = 1'b0;
        for (int unsigned k = 0; k < NoReq; k++) begin
            cand = IdxWidth'((32'(ptr_q) + k) % NoReq);
            if (!found_winner && eligible[cand]) begin
                winner       = cand;
                found_winner = 1'b1;
            end
        end
    end

    always_comb begin
        free_slot  = '0;
        found_free = 1'b0;
        for (int unsigned s = 0; s < MaxOutstanding; s++) begin
            if (!found_free && !slot_busy_q[SlotWidth'(s)]) begin
                free_slot  = SlotWidth'(s);
                found_free = 1'b1;
            end
        end
    end

    assign sel_addr = req_addr_i[32'(winner)*CmAddrWidth +: CmAddrWidth];
    assign load     = !stall_i && found_free && found_winner &&
                      ((state_q == EMPTY) || snp_ready_i);
    assign done_hit = done_valid_i && (32'(done_slot_i) < MaxOutstanding) &&
                      slot_busy_q[done_slot_i];

    always_comb begin
        req_ready_o = '0;
        if (load) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (snp_ready_i && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            slot_busy_q <= '0;
            slot_addr_q <= '{default: '0};
            ptr_q       <= '0;
            req_idx_q   <= '0;
            addr_q      <= '0;
            slot_q      <= '0;
            busy_q      <= '0;
        end else begin
            state_q <= state_d;
            if (done_hit) begin
                slot_busy_q[done_slot_i] <= 1'b0;
            end
            // Allocation uses the pre-edge free vector, so it never collides with done.
            if (load) begin
                slot_busy_q[free_slot] <= 1'b1;
                slot_addr_q[free_slot] <= sel_addr;
                req_idx_q              <= winner;
                addr_q                 <= sel_addr;
                slot_q                 <= free_slot;
                ptr_q                  <= (32'(winner) == NoReq - 1) ? '0 : winner + 1'b1;
            end
            case ({load, done_hit})
                2'b10:   busy_q <= busy_q + 1'b1;
                2'b01:   busy_q <= busy_q - 1'b1;
                default: busy_q <= busy_q;
            endcase
        end
    end

    assign snp_valid_o   = (state_q == FULL);
    assign snp_req_idx_o = req_idx_q;
    assign snp_addr_o    = addr_q;
    assign snp_slot_o    = slot_q;
    assign busy_cnt_o    = busy_q;

    for (genvar i = 0; i < NoReq; i++) begin : g_req_stable
        a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[i] && !req_ready_o[i]) |=>
            (req_valid_i[i] && $stable(req_addr_i[i*CmAddrWidth +: CmAddrWidth])));
    end

    a_done_range: assert property (@(posedge clk_i) disable iff (rst_i)
        done_valid_i |-> (32'(done_slot_i) < MaxOutstanding));

    a_done_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        done_valid_i |-> slot_busy_q[done_slot_i]);

endmodule

// File: tb/tb_ace_ccu_snoop_scheduler.sv
// Directed bench for ace_ccu_snoop_scheduler: reset, issue, round-robin, conflict,
// backpressure, stall and mid-operation reset, with hand-computed expectations.
module tb_ace_ccu_snoop_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_ready_o;
    logic        stall_i;
    logic        snp_valid_o;
    logic [1:0]  snp_req_idx_o;
    logic [7:0]  snp_addr_o;
    logic [1:0]  snp_slot_o;
    logic        snp_ready_i;
    logic        done_valid_i;
    logic [1:0]  done_slot_i;
    logic [2:0]  busy_cnt_o;

    int checks   = 0;
    int failures = 0;

    ace_ccu_snoop_scheduler #(
        .NoReq(4),
        .CmAddrWidth(8),
        .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_addr_i(req_addr_i),
        .req_ready_o(req_ready_o),
        .stall_i(stall_i),
        .snp_valid_o(snp_valid_o),
        .snp_req_idx_o(snp_req_idx_o),
        .snp_addr_o(snp_addr_o),
        .snp_slot_o(snp_slot_o),
        .snp_ready_i(snp_ready_i),
        .done_valid_i(done_valid_i),
        .done_slot_i(done_slot_i),
        .busy_cnt_o(busy_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                             input logic [7:0] addr, input logic [1:0] slot);
        chk({tag, "_valid"}, 32'(snp_valid_o), 32'(v));
        chk({tag, "_idx"},   32'(snp_req_idx_o), 32'(idx));
        chk({tag, "_addr"},  32'(snp_addr_o), 32'(addr));
        chk({tag, "_slot"},  32'(snp_slot_o), 32'(slot));
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a);
        req_valid_i[i]       = v;
        req_addr_i[i*8 +: 8] = a;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = '0;
        req_addr_i   = '0;
        stall_i      = 1'b0;
        snp_ready_i  = 1'b0;
        done_valid_i = 1'b0;
        done_slot_i  = '0;

        // Reset state
        tick();
        tick();
        mid();
        check_out("rst", 1'b0, 2'd0, 8'h00, 2'd0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_busy",  32'(busy_cnt_o), 32'd0);
        tick();
        rst_i = 1'b0;

        // Single request
        snp_ready_i = 1'b1;
        set_req(0, 1'b1, 8'h12);
        mid();
        chk("single_ready", 32'(req_ready_o), 32'h1);
        tick();
        set_req(0, 1'b0, 8'h00);
        mid();
        check_out("single_out", 1'b1, 2'd0, 8'h12, 2'd0);
        chk("single_busy", 32'(busy_cnt_o), 32'd1);
        chk("single_ready_off", 32'(req_ready_o), 32'h0);
        tick();
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        mid();
        chk("single_drained", 32'(snp_valid_o), 32'd0);
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("single_freed", 32'(busy_cnt_o), 32'd0);

        // Round-robin fill of all slots, then a waiting fifth request
        do_reset();
        snp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'(k + 1));
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("rr_ready", 32'(req_ready_o), 32'h1 << k);
            if (k > 0) check_out("rr_out", 1'b1, 2'(k - 1), 8'(k), 2'(k - 1));
            tick();
            set_req(k, 1'b0, 8'h00);
        end
        mid();
        check_out("rr_last", 1'b1, 2'd3, 8'h04, 2'd3);
        chk("rr_busy4", 32'(busy_cnt_o), 32'd4);
        tick();
        set_req(0, 1'b1, 8'h05);
        mid();
        chk("full_ready", 32'(req_ready_o), 32'h0);
        chk("full_busy", 32'(busy_cnt_o), 32'd4);
        chk("full_idle", 32'(snp_valid_o), 32'd0);
        tick();
        mid();
        chk("full_ready2", 32'(req_ready_o), 32'h0);
        tick();
        done_valid_i = 1'b1;
        done_slot_i  = 2'd2;
        mid();
        chk("full_done_cycle", 32'(req_ready_o), 32'h0);
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("full_reopen_ready", 32'(req_ready_o), 32'h1);
        chk("full_reopen_busy", 32'(busy_cnt_o), 32'd3);
        tick();
        set_req(0, 1'b0, 8'h00);
        mid();
        check_out("full_reuse", 1'b1, 2'd0, 8'h05, 2'd2);
        chk("full_reuse_busy", 32'(busy_cnt_o), 32'd4);
        for (int s = 0; s < 4; s++) begin
            tick();
            done_valid_i = 1'b1;
            done_slot_i  = 2'(s);
        end
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("rr_drain_busy", 32'(busy_cnt_o), 32'd0);

        // Address conflict blocks until the slot completes
        do_reset();
        set_req(0, 1'b1, 8'h20);
        mid();
        chk("cf_ready0", 32'(req_ready_o), 32'h1);
        tick();
        set_req(0, 1'b0, 8'h00);
        set_req(1, 1'b1, 8'h20);
        mid();
        chk("cf_blocked_a", 32'(req_ready_o), 32'h0);
        check_out("cf_out0", 1'b1, 2'd0, 8'h20, 2'd0);
        tick();
        mid();
        chk("cf_blocked_b", 32'(req_ready_o), 32'h0);
        tick();
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        mid();
        chk("cf_blocked_done", 32'(req_ready_o), 32'h0);
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("cf_unblock", 32'(req_ready_o), 32'h2);
        chk("cf_busy0", 32'(busy_cnt_o), 32'd0);
        tick();
        set_req(1, 1'b0, 8'h00);
        mid();
        check_out("cf_out1", 1'b1, 2'd1, 8'h20, 2'd0);
        chk("cf_busy1", 32'(busy_cnt_o), 32'd1);
        tick();
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        mid();
        chk("cf_drained", 32'(snp_valid_o), 32'd0);
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("cf_freed", 32'(busy_cnt_o), 32'd0);

        // Backpressure holds outputs, then a back-to-back load (pointer is now 2)
        tick();
        snp_ready_i = 1'b0;
        set_req(2, 1'b1, 8'h30);
        mid();
        chk("bp_ready2", 32'(req_ready_o), 32'h4);
        tick();
        set_req(2, 1'b0, 8'h00);
        set_req(3, 1'b1, 8'h31);
        for (int c = 0; c < 5; c++) begin
            mid();
            check_out("bp_hold", 1'b1, 2'd2, 8'h30, 2'd0);
            chk("bp_noaccept", 32'(req_ready_o), 32'h0);
            tick();
        end
        snp_ready_i = 1'b1;
        mid();
        chk("bp_b2b_ready", 32'(req_ready_o), 32'h8);
        tick();
        set_req(3, 1'b0, 8'h00);
        mid();
        check_out("bp_b2b_out", 1'b1, 2'd3, 8'h31, 2'd1);
        chk("bp_busy2", 32'(busy_cnt_o), 32'd2);
        tick();
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        mid();
        chk("bp_drained", 32'(snp_valid_o), 32'd0);
        tick();
        done_slot_i = 2'd1;
        tick();
        done_valid_i = 1'b0;
        mid();
        chk("bp_freed", 32'(busy_cnt_o), 32'd0);

        // Stall blocks issue (pointer is now 0)
        tick();
        stall_i = 1'b1;
        set_req(0, 1'b1, 8'h40);
        set_req(1, 1'b1, 8'h41);
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("stall_ready", 32'(req_ready_o), 32'h0);
            chk("stall_busy", 32'(busy_cnt_o), 32'd0);
            tick();
        end
        stall_i = 1'b0;
        mid();
        chk("stall_release", 32'(req_ready_o), 32'h1);
        tick();
        set_req(0, 1'b0, 8'h00);
        mid();
        chk("stall_next", 32'(req_ready_o), 32'h2);
        check_out("stall_out0", 1'b1, 2'd0, 8'h40, 2'd0);
        tick();
        set_req(1, 1'b0, 8'h00);
        mid();
        check_out("stall_out1", 1'b1, 2'd1, 8'h41, 2'd1);
        chk("stall_busy2", 32'(busy_cnt_o), 32'd2);
        tick();

        // Mid-operation reset with three slots busy and output held (pointer is now 2)
        snp_ready_i = 1'b0;
        set_req(2, 1'b1, 8'h50);
        mid();
        chk("mr_ready", 32'(req_ready_o), 32'h4);
        tick();
        set_req(2, 1'b0, 8'h00);
        mid();
        chk("mr_busy3", 32'(busy_cnt_o), 32'd3);
        chk("mr_full", 32'(snp_valid_o), 32'd1);
        tick();
        rst_i = 1'b1;
        mid();
        chk("mr_busy0", 32'(busy_cnt_o), 32'd0);
        chk("mr_valid0", 32'(snp_valid_o), 32'd0);
        chk("mr_ready0", 32'(req_ready_o), 32'h0);
        tick();
        rst_i       = 1'b0;
        snp_ready_i = 1'b1;
        set_req(3, 1'b1, 8'h60);
        set_req(0, 1'b1, 8'h61);
        mid();
        chk("mr_ptr0", 32'(req_ready_o), 32'h1);
        tick();
        set_req(0, 1'b0, 8'h00);
        mid();
        check_out("mr_out0", 1'b1, 2'd0, 8'h61, 2'd0);
        chk("mr_next", 32'(req_ready_o), 32'h8);
        chk("mr_busy1", 32'(busy_cnt_o), 32'd1);
        tick();
        set_req(3, 1'b0, 8'h00);
        mid();
        check_out("mr_out3", 1'b1, 2'd3, 8'h60, 2'd1);
        chk("mr_busy2", 32'(busy_cnt_o), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
